collision_scanner: RTL and testbench

- Parametrised successor to the single-tile player/ground contact checker.
- Sequentially scans a table of N_TILES terrain tiles for one player sprite and reports side-contact flags (down, up, right, left), ORed across all enabled tiles.
- Sits between the player motion logic and the level tile RAM. Runs one scan per frame on a start pulse.
- Uses a start/busy/done handshake.

---
 rtl/collision_pkg.sv | 15 +
 rtl/collision_side_check.sv | 58 +++++
 rtl/collision_scanner.sv | 137 +++++++++++++
 tb/tb_collision_scanner.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/collision_pkg.sv
// Shared definitions for the collision scanner: side-flag bit positions and FSM states.
package collision_pkg;

  localparam int SIDE_DOWN  = 0;
  localparam int SIDE_UP    = 1;
  localparam int SIDE_RIGHT = 2;
  localparam int SIDE_LEFT  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } scan_state_t;

endpackage

// File: rtl/collision_side_check.sv
// Combinational side-contact test between one sprite and one tile.
// Returns {left, right, up, down}; all flags are zero when the tile is disabled.
module collision_side_check
  import collision_pkg::*;
#(
  parameter int X_W    = 10,
  parameter int Y_W    = 9,
  parameter int PW     = 23,
  parameter int PH     = 45,
  parameter int TW     = 25,
  parameter int TH     = 24,
  parameter int MARGIN = 2
) (
  input  logic [X_W-1:0] i_xp,
  input  logic [Y_W-1:0] i_yp,
  input  logic [X_W-1:0] i_xt,
  input  logic [Y_W-1:0] i_yt,
  input  logic           i_en,
  output logic [3:0]     o_flags
);

  localparam int XE = X_W + 1;
  localparam int YE = Y_W + 1;

  // One extra bit on every sum so edge-of-screen coordinates never wrap
  logic [X_W:0] w_xp, w_xt, w_xp_pw, w_xp_m, w_xt_m, w_xt_tw;
  logic [Y_W:0] w_yp, w_yt, w_yp_ph, w_yp_m, w_yt_m, w_yt_th;
  logic         w_hx, w_vy;

  assign w_xp    = {1'b0, i_xp};
  assign w_xt    = {1'b0, i_xt};
  assign w_yp    = {1'b0, i_yp};
  assign w_yt    = {1'b0, i_yt};

  assign w_xp_pw = w_xp + XE'(PW);
  assign w_xp_m  = w_xp + XE'(MARGIN);
  assign w_xt_m  = w_xt + XE'(MARGIN);
  assign w_xt_tw = w_xt + XE'(TW);

  assign w_yp_ph = w_yp + YE'(PH);
  assign w_yp_m  = w_yp + YE'(MARGIN);
  assign w_yt_m  = w_yt + YE'(MARGIN);
  assign w_yt_th = w_yt + YE'(TH);

  assign w_hx = (w_xp_pw > w_xt_m) && (w_xp_m < w_xt_tw);
  assign w_vy = (w_yp_ph > w_yt_m) && (w_yp_m < w_yt_th);

  always_comb begin
    o_flags = 4'b0000;
    if (i_en) begin
      o_flags[SIDE_DOWN]  = w_hx && (w_yp_ph == w_yt);
      o_flags[SIDE_UP]    = w_hx && (w_yp == w_yt_th);
      o_flags[SIDE_RIGHT] = w_vy && (w_xp_pw == w_xt);
      o_flags[SIDE_LEFT]  = w_vy && (w_xp == w_xt_tw);
    end
  end

endmodule

// File: rtl/collision_scanner.sv
// Scans N_TILES terrain tiles once per start pulse and reports ORed side-contact flags
// for the player sprite plus the number of tiles that touched it.
module collision_scanner
  import collision_pkg::*;
#(
  parameter int X_W     = 10,
  parameter int Y_W     = 9,
  parameter int PW      = 23,
  parameter int PH      = 45,
  parameter int TW      = 25,
  parameter int TH      = 24,
  parameter int MARGIN  = 2,
  parameter int N_TILES = 64,
  parameter int ADDR_W  = (N_TILES > 1) ? $clog2(N_TILES) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [X_W-1:0]    x_player,
  input  logic [Y_W-1:0]    y_player,
  output logic [ADDR_W-1:0] tile_addr,
  input  logic [X_W-1:0]    tile_x,
  input  logic [Y_W-1:0]    tile_y,
  input  logic              tile_en,
  output logic              busy,
  output logic              done,
  output logic [3:0]        is_collision,
  output logic [ADDR_W:0]   hit_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_TILES - 1);

  scan_state_t       r_state, w_next;
  logic [X_W-1:0]    r_xp;
  logic [Y_W-1:0]    r_yp;
  logic [ADDR_W-1:0] r_addr;
  logic              r_vld;
  logic [3:0]        r_acc;
  logic [ADDR_W:0]   r_cnt;
  logic [3:0]        r_coll;
  logic [ADDR_W:0]   r_hits;
  logic              r_done;

  logic              w_accept;
  logic              w_busy;
  logic [3:0]        w_flags;
  logic [3:0]        w_acc_nxt;
  logic [ADDR_W:0]   w_cnt_nxt;

  // Tile data lags its address by one cycle, so r_vld gates the checker
  collision_side_check #(
    .X_W(X_W), .Y_W(Y_W), .PW(PW), .PH(PH), .TW(TW), .TH(TH), .MARGIN(MARGIN)
  ) u_side_check (
    .i_xp   (r_xp),
    .i_yp   (r_yp),
    .i_xt   (tile_x),
    .i_yt   (tile_y),
    .i_en   (tile_en && r_vld),
    .o_flags(w_flags)
  );

  assign w_acc_nxt = r_acc | w_flags;
  assign w_cnt_nxt = r_cnt + {{ADDR_W{1'b0}}, |w_flags};

  // A start landing in the done cycle is dropped: the scan has not yet fully retired
  assign w_accept  = (r_state == ST_IDLE) && start && !r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = ST_SCAN;
      ST_SCAN:  if (r_addr == LAST_ADDR) w_next = ST_DRAIN;
      ST_DRAIN: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xp   <= '0;
      r_yp   <= '0;
      r_addr <= '0;
      r_vld  <= 1'b0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_coll <= '0;
      r_hits <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == ST_DRAIN);
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_xp   <= x_player;
            r_yp   <= y_player;
            r_addr <= '0;
            r_vld  <= 1'b0;
            r_acc  <= '0;
            r_cnt  <= '0;
          end
        end
        ST_SCAN: begin
          if (r_addr != LAST_ADDR) r_addr <= r_addr + 1'b1;
          r_vld <= 1'b1;
          r_acc <= w_acc_nxt;
          r_cnt <= w_cnt_nxt;
        end
        ST_DRAIN: begin
          r_coll <= w_acc_nxt;
          r_hits <= w_cnt_nxt;
          r_addr <= '0;
          r_vld  <= 1'b0;
        end
        default: begin
          r_addr <= '0;
          r_vld  <= 1'b0;
        end
      endcase
    end
  end

  assign tile_addr    = r_addr;
  assign busy         = w_busy;
  assign done         = r_done;
  assign is_collision = r_coll;
  assign hit_count    = r_hits;

endmodule

// File: tb/tb_collision_scanner.sv
// Scoreboard bench for collision_scanner with a 4-entry tile table model.
module tb_collision_scanner;

  localparam int NT = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [9:0]    x_player = '0;
  logic [8:0]    y_player = '0;
  logic [AW-1:0] tile_addr;
  logic [9:0]    tile_x = '0;
  logic [8:0]    tile_y = '0;
  logic          tile_en = 1'b0;
  logic          busy, done;
  logic [3:0]    is_collision;
  logic [AW:0]   hit_count;

  logic [9:0] tx [NT];
  logic [8:0] ty [NT];
  logic       ten[NT];

  typedef struct packed {
    logic [3:0]  c;
    logic [AW:0] h;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  collision_scanner #(.N_TILES(NT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .x_player(x_player), .y_player(y_player),
    .tile_addr(tile_addr), .tile_x(tile_x), .tile_y(tile_y), .tile_en(tile_en),
    .busy(busy), .done(done), .is_collision(is_collision), .hit_count(hit_count)
  );

  // Synchronous tile RAM: data appears one cycle after its address
  always @(posedge clk) begin
    tile_x  <= tx[tile_addr];
    tile_y  <= ty[tile_addr];
    tile_en <= ten[tile_addr];
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 expected=0");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("is_collision", int'(is_collision), int'(e.c));
        chk("hit_count", int'(hit_count), int'(e.h));
      end
    end
  end

  task automatic set_tile(input int i, input logic [9:0] x, input logic [8:0] y, input logic en);
    tx[i] = x; ty[i] = y; ten[i] = en;
  endtask

  task automatic clear_tiles();
    for (int i = 0; i < NT; i++) set_tile(i, 10'd0, 9'd0, 1'b0);
  endtask

  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=0 expected=1");
    end
  endtask

  task automatic do_scan(input logic [9:0] x, input logic [8:0] y,
                         input logic [3:0] ec, input logic [AW:0] eh);
    int n;
    sb.push_back('{c: ec, h: eh});
    @(negedge clk);
    x_player = x; y_player = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    chk("latency", n - 1, NT + 1);
    @(negedge clk);
  endtask

  initial begin
    int n;
    int d0;
    clear_tiles();
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_coll", int'(is_collision), 0);
    chk("rst_hits", int'(hit_count), 0);
    chk("rst_addr", int'(tile_addr), 0);
    rst_n = 1'b1;
    @(negedge clk);

    set_tile(0, 10'd100, 9'd200, 1'b1);
    do_scan(10'd80,  9'd155, 4'b0001, 3'd1);
    do_scan(10'd80,  9'd224, 4'b0010, 3'd1);
    do_scan(10'd77,  9'd190, 4'b0100, 3'd1);
    do_scan(10'd125, 9'd190, 4'b1000, 3'd1);
    do_scan(10'd79,  9'd155, 4'b0000, 3'd0);

    set_tile(0, 10'd100, 9'd200, 1'b0);
    set_tile(3, 10'd100, 9'd200, 1'b1);
    do_scan(10'd80, 9'd155, 4'b0001, 3'd1);
    clear_tiles();
    do_scan(10'd80, 9'd155, 4'b0000, 3'd0);

    // tile1 sits so the player's left edge (x=80) abuts its right edge (55+25)
    set_tile(0, 10'd100, 9'd200, 1'b1);
    set_tile(1, 10'd55,  9'd150, 1'b1);
    do_scan(10'd80, 9'd155, 4'b1001, 3'd2);

    clear_tiles();
    set_tile(0, 10'd100, 9'd200, 1'b1);
    d0 = done_cnt;
    sb.push_back('{c: 4'b0001, h: 3'd1});
    @(negedge clk);
    x_player = 10'd80; y_player = 9'd155; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("busy_mid_scan", int'(busy), 1);
    x_player = 10'd77; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    repeat (10) @(negedge clk);
    chk("single_done", done_cnt - d0, 1);

    d0 = done_cnt;
    x_player = 10'd80; y_player = 9'd224; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_coll", int'(is_collision), 0);
    chk("abort_hits", int'(hit_count), 0);
    chk("abort_addr", int'(tile_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);

    do_scan(10'd80, 9'd224, 4'b0010, 3'd1);
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
